// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the per-cycle
// latch-control decision and a width helper for the memory wait counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  typedef struct packed {
    logic fe_en;
    logic fe_clear;
    logic de_en;
    logic de_clear;
    logic exe_en;
  } decision_t;

  localparam decision_t DEC_NONE   = '{fe_en: 1'b1, fe_clear: 1'b0, de_en: 1'b1, de_clear: 1'b0, exe_en: 1'b1};
  localparam decision_t DEC_FREEZE = '{fe_en: 1'b0, fe_clear: 1'b0, de_en: 1'b0, de_clear: 1'b0, exe_en: 1'b0};
  localparam decision_t DEC_REDIR  = '{fe_en: 1'b1, fe_clear: 1'b1, de_en: 1'b1, de_clear: 1'b1, exe_en: 1'b1};
  localparam decision_t DEC_BUBBLE = '{fe_en: 1'b0, fe_clear: 1'b0, de_en: 1'b1, de_clear: 1'b1, exe_en: 1'b1};

  // Ceiling log2, floored at 1 so the wait counter always has at least one bit.
  function automatic int unsigned wcnt_width(input int unsigned timeout);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < timeout) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with natural modulo-2^CNT_W wrap.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: combinational stall/flush decisions
// from load-use, redirect and data-memory wait conditions, plus a timeout FSM.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] de_src0_i,
  input  logic [ADDR_W-1:0] de_src1_i,
  input  logic              de_has_imm_i,
  input  logic              exe_mem2rf_i,
  input  logic              exe_rf_we_i,
  input  logic [ADDR_W-1:0] exe_rf_waddr_i,
  input  logic              exe_redirect_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  output logic              fe_en_o,
  output logic              fe_clear_o,
  output logic              de_en_o,
  output logic              de_clear_o,
  output logic              exe_en_o,
  output logic              fault_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int unsigned WCNT_W = wcnt_width(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              fault_q;
  logic              lu, ms;
  decision_t         dec;
  logic              redirect_win;

  // A load into x0 never produces a value worth waiting for.
  assign lu = exe_mem2rf_i && exe_rf_we_i && (exe_rf_waddr_i != '0) &&
              ((exe_rf_waddr_i == de_src0_i) ||
               ((exe_rf_waddr_i == de_src1_i) && !de_has_imm_i));
  assign ms = dmem_req_i && !dmem_ack_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fault_q <= (state_d == FAULT);
    end
  end

  // NOTE: defaults first in every combinational block, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (ms) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i || !dmem_req_i) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = FAULT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  // Held reset releases the datapath; otherwise fault > mem stall > redirect > load-use.
  always_comb begin
    dec          = DEC_NONE;
    redirect_win = 1'b0;
    if (reset) begin
      dec = DEC_NONE;
    end else if (state_q == FAULT) begin
      dec = DEC_FREEZE;
    end else if (ms) begin
      dec = DEC_FREEZE;
    end else if (exe_redirect_i) begin
      dec          = DEC_REDIR;
      redirect_win = 1'b1;
    end else if (lu) begin
      dec = DEC_BUBBLE;
    end
  end

  assign fe_en_o    = dec.fe_en;
  assign fe_clear_o = dec.fe_clear;
  assign de_en_o    = dec.de_en;
  assign de_clear_o = dec.de_clear;
  assign exe_en_o   = dec.exe_en;
  assign fault_o    = fault_q;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!dec.fe_en),
    .count (stall_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect_win),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4): directed vectors
// push hand-computed expectations; a monitor pops and compares every cycle.
module tb_hazard_ctrl;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int MEM_TO = 4;

  // Packed decision order: fe_en, fe_clear, de_en, de_clear, exe_en
  localparam logic [4:0] D_NONE   = 5'b10101;
  localparam logic [4:0] D_FREEZE = 5'b00000;
  localparam logic [4:0] D_REDIR  = 5'b11111;
  localparam logic [4:0] D_BUBBLE = 5'b00111;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] de_src0, de_src1, exe_rf_waddr;
  logic              de_has_imm, exe_mem2rf, exe_rf_we, exe_redirect;
  logic              dmem_req, dmem_ack;
  logic              fe_en, fe_clear, de_en, de_clear, exe_en, fault;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  typedef struct {
    string           name;
    logic [4:0]      dec;
    logic            fault;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  always #5 clk = ~clk;

  hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .de_src0_i      (de_src0),
    .de_src1_i      (de_src1),
    .de_has_imm_i   (de_has_imm),
    .exe_mem2rf_i   (exe_mem2rf),
    .exe_rf_we_i    (exe_rf_we),
    .exe_rf_waddr_i (exe_rf_waddr),
    .exe_redirect_i (exe_redirect),
    .dmem_req_i     (dmem_req),
    .dmem_ack_i     (dmem_ack),
    .fe_en_o        (fe_en),
    .fe_clear_o     (fe_clear),
    .de_en_o        (de_en),
    .de_clear_o     (de_clear),
    .exe_en_o       (exe_en),
    .fault_o        (fault),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: mid-low-phase, the combinational decisions for the current
  // inputs and the counters from completed cycles are stable.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".dec"},   {27'd0, fe_en, fe_clear, de_en, de_clear, exe_en}, {27'd0, e.dec});
        check({e.name, ".fault"}, {31'd0, fault}, {31'd0, e.fault});
        check({e.name, ".stall"}, {28'd0, stall_cnt}, {28'd0, e.stall});
        check({e.name, ".flush"}, {28'd0, flush_cnt}, {28'd0, e.flush});
      end
    end
  end

  task automatic push(input string name, input logic [4:0] dec, input logic flt);
    exp_t e;
    e.name  = name;
    e.dec   = dec;
    e.fault = flt;
    e.stall = exp_stall;
    e.flush = exp_flush;
    sb.push_back(e);
  endtask

  // One clock cycle of stimulus with its expected decision and fault level.
  task automatic step(input string name,
                      input logic [4:0] s0, input logic [4:0] s1, input logic imm,
                      input logic ld, input logic we, input logic [4:0] wa,
                      input logic rd, input logic req, input logic ack,
                      input logic [4:0] dec, input logic flt);
    @(negedge clk);
    reset        = 1'b0;
    de_src0      = s0;
    de_src1      = s1;
    de_has_imm   = imm;
    exe_mem2rf   = ld;
    exe_rf_we    = we;
    exe_rf_waddr = wa;
    exe_redirect = rd;
    dmem_req     = req;
    dmem_ack     = ack;
    push(name, dec, flt);
    if (dec[4] == 1'b0) exp_stall = exp_stall + 1'b1;
    if (dec == D_REDIR) exp_flush = exp_flush + 1'b1;
  endtask

  task automatic idle(input string name);
    step(name, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, D_NONE, 1'b0);
  endtask

  // Asserts reset between clock edges, keeping a memory request pending.
  task automatic reset_step(input string name, input logic req);
    @(negedge clk);
    reset     = 1'b1;
    dmem_req  = req;
    dmem_ack  = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    push(name, D_NONE, 1'b0);
  endtask

  initial begin
    de_src0 = '0; de_src1 = '0; de_has_imm = 1'b0;
    exe_mem2rf = 1'b0; exe_rf_we = 1'b0; exe_rf_waddr = '0;
    exe_redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;

    reset_step("reset_hold", 1'b1);
    idle("idle0");
    // Load-use cases
    step("lu_src0",     5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, D_BUBBLE, 1'b0);
    idle("after_lu");
    step("imm_no_lu",   5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, D_NONE,   1'b0);
    step("x0_no_lu",    5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, D_NONE,   1'b0);
    step("lu_src1",     5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, D_BUBBLE, 1'b0);
    step("no_we",       5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, D_NONE,   1'b0);
    step("not_load",    5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, D_NONE,   1'b0);
    step("redir_lu",    5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, D_REDIR,  1'b0);
    idle("after_redir");
    // Memory wait of 3 cycles, ack lands exactly as wcnt hits MEM_TIMEOUT-1
    step("ms_redir_lu", 5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("ms_w1",       5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("ms_w2",       5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("ack_at_last", 5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, D_REDIR,  1'b0);
    idle("after_mem");
    step("ack_first",   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, D_NONE,   1'b0);
    step("ack_first_lu",5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, D_BUBBLE, 1'b0);
    // Request dropped without ack returns to RUN, then a full timeout
    step("drop_w0",     5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("drop",        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, D_NONE,   1'b0);
    step("to_w0",       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("to_w1",       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("to_w2",       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("to_w3",       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, D_FREEZE, 1'b0);
    step("fault0",      5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, D_FREEZE, 1'b1);
    step("fault_ack",   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, D_FREEZE, 1'b1);
    step("fault_redir", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, D_FREEZE, 1'b1);
    reset_step("reset_in_fault", 1'b1);
    step("post_reset",  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, D_NONE,   1'b0);
    // 17 redirects on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) begin
      step($sformatf("redir%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, D_REDIR, 1'b0);
    end
    idle("after_wrap");
    idle("final");

    // Allow the monitor a bounded time to drain the scoreboard.
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    #5;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
